// File: rtl/mmio_pkg.sv
// I/O window base and register offsets for the CPU memory responder.
package mmio_pkg;

  localparam logic [31:0] IO_BASE_DFLT = 32'hFFFF_FF00;

  localparam logic [7:0] OFS_SW    = 8'h00;
  localparam logic [7:0] OFS_BTN   = 8'h04;
  localparam logic [7:0] OFS_LED   = 8'h08;
  localparam logic [7:0] OFS_DISP  = 8'h0C;
  localparam logic [7:0] OFS_TCNT  = 8'h10;
  localparam logic [7:0] OFS_TCMP  = 8'h14;
  localparam logic [7:0] OFS_TSTAT = 8'h18;

  // Word-aligned offset inside the I/O window; byte lane bits are dropped.
  function automatic logic [7:0] word_ofs(input logic [31:0] a);
    return {a[7:2], 2'b00};
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running compare timer: TCNT counts while enabled, sticky flag on TCNT == TCMP.
// Register writes take effect on the strobe edge; no backpressure.
module mmio_timer (
  input  logic        clk_cpu,
  input  logic        rst_cpu,
  input  logic        wr_tcnt,
  input  logic        wr_tcmp,
  input  logic        wr_tstat,
  input  logic [31:0] wdata,
  output logic [31:0] tcnt,
  output logic [31:0] tcmp,
  output logic        enable,
  output logic        timer_flag
);

  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      tcnt       <= 32'h0;
      tcmp       <= 32'hFFFF_FFFF;
      enable     <= 1'b0;
      timer_flag <= 1'b0;
    end else begin
      // A CPU load of TCNT beats the increment in the same cycle.
      if (wr_tcnt)     tcnt <= wdata;
      else if (enable) tcnt <= tcnt + 32'd1;

      if (wr_tcmp)  tcmp   <= wdata;
      if (wr_tstat) enable <= wdata[1];

      // Setting beats a write-1-to-clear landing on the same edge.
      if (enable && (tcnt == tcmp))     timer_flag <= 1'b1;
      else if (wr_tstat && wdata[0])    timer_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// CPU memory responder: routes loads/stores to RAM or the I/O register bank; rdata valid one cycle after a load.
// Compare timer present only when MMIO_TIMER_EN is defined; no backpressure, RAM strobes are combinational.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DFLT
) (
  input  logic        clk_cpu,
  input  logic        rst_cpu,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ram_rd,
  output logic        ram_wr,
  input  logic [31:0] ram_rdata,
  input  logic [7:0]  sw,
  input  logic [3:0]  btn,
  output logic [15:0] led_reg,
  output logic [15:0] disp_reg,
  output logic        timer_flag
);

  logic        io_hit;
  logic        rd_req;
  logic        io_rd;
  logic        io_wr;
  logic [7:0]  ofs;
  logic [7:0]  sw_s1, sw_s2;
  logic [3:0]  btn_s1, btn_s2, btn_s3;
  logic [3:0]  btn_evt;
  logic        btn_clr;
  logic [31:0] io_val;
  logic [31:0] io_q;
  logic        sel_io;
  logic [31:0] tcnt;
  logic [31:0] tcmp;
  logic        tmr_en;
  logic        unused_bits;

  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  assign io_hit = (addr[31:8] == IO_BASE[31:8]);
  // A simultaneous read+write is a pure write.
  assign rd_req = mem_read & ~mem_write;
  assign io_rd  = rd_req & io_hit;
  assign io_wr  = mem_write & io_hit;
  assign ofs    = word_ofs(addr);

  assign ram_rd = rd_req & ~io_hit;
  assign ram_wr = mem_write & ~io_hit;

  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      sw_s1  <= 8'h0;
      sw_s2  <= 8'h0;
      btn_s1 <= 4'h0;
      btn_s2 <= 4'h0;
      btn_s3 <= 4'h0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  assign btn_clr = io_rd && (ofs == OFS_BTN);

  // A fresh edge survives a clearing read on the same cycle.
  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) btn_evt <= 4'h0;
    else         btn_evt <= (btn_clr ? 4'h0 : btn_evt) | (btn_s2 & ~btn_s3);
  end

  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      led_reg  <= 16'h0;
      disp_reg <= 16'h0;
    end else if (io_wr) begin
      if (ofs == OFS_LED)  led_reg  <= wdata[15:0];
      if (ofs == OFS_DISP) disp_reg <= wdata[15:0];
    end
  end

`ifdef MMIO_TIMER_EN
  logic wr_tcnt, wr_tcmp, wr_tstat;

  assign wr_tcnt  = io_wr && (ofs == OFS_TCNT);
  assign wr_tcmp  = io_wr && (ofs == OFS_TCMP);
  assign wr_tstat = io_wr && (ofs == OFS_TSTAT);

  mmio_timer u_timer (
    .clk_cpu    (clk_cpu),
    .rst_cpu    (rst_cpu),
    .wr_tcnt    (wr_tcnt),
    .wr_tcmp    (wr_tcmp),
    .wr_tstat   (wr_tstat),
    .wdata      (wdata),
    .tcnt       (tcnt),
    .tcmp       (tcmp),
    .enable     (tmr_en),
    .timer_flag (timer_flag)
  );
`else
  assign tcnt       = 32'h0;
  assign tcmp       = 32'h0;
  assign tmr_en     = 1'b0;
  assign timer_flag = 1'b0;
`endif

  always_comb begin
    io_val = 32'h0;
    case (ofs)
      OFS_SW:    io_val = {24'h0, sw_s2};
      OFS_BTN:   io_val = {28'h0, btn_evt};
      OFS_LED:   io_val = {16'h0, led_reg};
      OFS_DISP:  io_val = {16'h0, disp_reg};
      OFS_TCNT:  io_val = tcnt;
      OFS_TCMP:  io_val = tcmp;
      OFS_TSTAT: io_val = {30'h0, tmr_en, timer_flag};
      default:   io_val = 32'h0;
    endcase
  end

  // sel_io resets high so the held I/O word (zero) is what rdata shows out of reset.
  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      sel_io <= 1'b1;
      io_q   <= 32'h0;
    end else if (rd_req) begin
      sel_io <= io_hit;
      if (io_hit) io_q <= io_val;
    end
  end

  assign rdata = sel_io ? io_q : ram_rdata;

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed scenarios plus random traffic against a register-level reference model.
module tb_mmio_responder;
  import mmio_pkg::*;

  logic        clk_cpu = 1'b0;
  logic        rst_cpu;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata, rdata, ram_rdata;
  logic        ram_rd, ram_wr;
  logic [7:0]  sw;
  logic [3:0]  btn;
  logic [15:0] led_reg, disp_reg;
  logic        timer_flag;

  int checks = 0;
  int passed = 0;

  mmio_responder dut (
    .clk_cpu(clk_cpu), .rst_cpu(rst_cpu), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_rdata(ram_rdata), .sw(sw), .btn(btn), .led_reg(led_reg), .disp_reg(disp_reg),
    .timer_flag(timer_flag)
  );

  always #5 clk_cpu = ~clk_cpu;

  // Synchronous RAM in front of the responder; output holds between reads.
  logic [31:0] ram_mem [logic [29:0]];
  always @(posedge clk_cpu) begin
    if (ram_rd) ram_rdata <= ram_mem.exists(addr[31:2]) ? ram_mem[addr[31:2]] : 32'h0;
    if (ram_wr) ram_mem[addr[31:2]] = wdata;
  end

  // Reference model: architectural register values plus input sample histories.
  logic [31:0] io_base;
  logic [31:0] exp_rdata;
  logic [15:0] m_led, m_disp;
  logic [3:0]  m_evt;
  logic [3:0]  bh [3];
  logic [7:0]  sh [2];
  logic [31:0] m_tcnt, m_tcmp;
  logic        m_en, m_flag;

  task automatic model_reset();
    exp_rdata = 0; m_led = 0; m_disp = 0; m_evt = 0;
    for (int i = 0; i < 3; i++) bh[i] = 0;
    sh[0] = 0; sh[1] = 0;
    m_tcnt = 0; m_tcmp = 32'hFFFF_FFFF; m_en = 0; m_flag = 0;
  endtask

  // Applies one clock edge's worth of architectural effects using the inputs presented now.
  task automatic model_edge();
    logic        rd, hit, w1c;
    logic [7:0]  o;
    logic [31:0] v;
    rd  = mem_read & ~mem_write;
    hit = (addr[31:8] == io_base[31:8]);
    o   = {addr[7:2], 2'b00};
    v   = 0;
    if (o == OFS_SW)    v = {24'h0, sh[1]};
    if (o == OFS_BTN)   v = {28'h0, m_evt};
    if (o == OFS_LED)   v = {16'h0, m_led};
    if (o == OFS_DISP)  v = {16'h0, m_disp};
`ifdef MMIO_TIMER_EN
    if (o == OFS_TCNT)  v = m_tcnt;
    if (o == OFS_TCMP)  v = m_tcmp;
    if (o == OFS_TSTAT) v = {30'h0, m_en, m_flag};
`endif
    if (rd) exp_rdata = hit ? v : (ram_mem.exists(addr[31:2]) ? ram_mem[addr[31:2]] : 32'h0);
    m_evt = ((rd && hit && o == OFS_BTN) ? 4'h0 : m_evt) | (bh[1] & ~bh[2]);
    if (mem_write && hit && o == OFS_LED)  m_led  = wdata[15:0];
    if (mem_write && hit && o == OFS_DISP) m_disp = wdata[15:0];
`ifdef MMIO_TIMER_EN
    w1c    = mem_write && hit && o == OFS_TSTAT && wdata[0];
    m_flag = (m_en && m_tcnt == m_tcmp) || (m_flag && !w1c);
    if (mem_write && hit && o == OFS_TCNT) m_tcnt = wdata;
    else if (m_en)                         m_tcnt = m_tcnt + 1;
    if (mem_write && hit && o == OFS_TCMP)  m_tcmp = wdata;
    if (mem_write && hit && o == OFS_TSTAT) m_en = wdata[1];
`else
    w1c = 0;
`endif
    bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = btn;
    sh[1] = sh[0]; sh[0] = sw;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk_cpu);
    @(negedge clk_cpu);
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    mem_read = r; mem_write = w; addr = a; wdata = d;
  endtask

  task automatic test_reset();
    rst_cpu = 0; mem_read = 0; mem_write = 0; addr = 0; wdata = 0;
    sw = 0; btn = 0; ram_rdata = 0;
    #1 rst_cpu = 1;
    #1;
    checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rdata); else passed++;
    checks++; if (led_reg !== 16'h0) $display("FAIL reset_led: got %h expected 0", led_reg); else passed++;
    checks++; if (disp_reg !== 16'h0) $display("FAIL reset_disp: got %h expected 0", disp_reg); else passed++;
    checks++; if (timer_flag !== 1'b0) $display("FAIL reset_flag: got %b expected 0", timer_flag); else passed++;
    checks++; if ({ram_rd, ram_wr} !== 2'b00) $display("FAIL reset_strobes: got %b expected 00", {ram_rd, ram_wr}); else passed++;
    @(negedge clk_cpu); @(negedge clk_cpu);
    rst_cpu = 0;
    model_reset();
  endtask

  task automatic test_ram_path();
    drive(0, 1, 32'h40, 32'h1234_5678);
    #1;
    checks++; if ({ram_wr, ram_rd} !== 2'b10) $display("FAIL ram_store_strobes: got %b expected 10", {ram_wr, ram_rd}); else passed++;
    cycle();
    drive(1, 0, 32'h40, 32'h0);
    #1;
    checks++; if ({ram_wr, ram_rd} !== 2'b01) $display("FAIL ram_load_strobes: got %b expected 01", {ram_wr, ram_rd}); else passed++;
    cycle();
    drive(0, 0, 32'h0, 32'h0);
    checks++; if (rdata !== 32'h1234_5678) $display("FAIL ram_load_data: got %h expected 12345678", rdata); else passed++;
    cycle(); cycle();
    checks++; if (rdata !== 32'h1234_5678) $display("FAIL ram_load_hold: got %h expected 12345678", rdata); else passed++;
  endtask

  task automatic test_led_disp();
    drive(0, 1, 32'hFFFF_FF08, 32'h0000_ABCD);
    #1;
    checks++; if (ram_wr !== 1'b0) $display("FAIL io_store_no_ram_wr: got %b expected 0", ram_wr); else passed++;
    cycle();
    checks++; if (led_reg !== 16'hABCD) $display("FAIL led_write: got %h expected abcd", led_reg); else passed++;
    drive(0, 1, 32'hFFFF_FF0E, 32'hFFFF_5A5A);
    cycle();
    checks++; if (disp_reg !== 16'h5A5A) $display("FAIL disp_write: got %h expected 5a5a", disp_reg); else passed++;
    drive(1, 0, 32'hFFFF_FF20, 32'h0);
    #1;
    checks++; if (ram_rd !== 1'b0) $display("FAIL io_load_no_ram_rd: got %b expected 0", ram_rd); else passed++;
    cycle();
    checks++; if (rdata !== 32'h0) $display("FAIL unmapped_read: got %h expected 0", rdata); else passed++;
    drive(1, 0, 32'hFFFF_FF08, 32'h0);
    cycle();
    checks++; if (rdata !== 32'h0000_ABCD) $display("FAIL led_readback: got %h expected 0000abcd", rdata); else passed++;
    drive(1, 1, 32'hFFFF_FF0C, 32'h1111);
    cycle();
    checks++; if (rdata !== 32'h0000_ABCD) $display("FAIL rdwr_holds_rdata: got %h expected 0000abcd", rdata); else passed++;
    checks++; if (disp_reg !== 16'h1111) $display("FAIL rdwr_is_write: got %h expected 1111", disp_reg); else passed++;
    drive(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_sw();
    logic [7:0] v;
    v = 8'($urandom_range(1, 255));
    sw = v;
    cycle(); cycle(); cycle();
    drive(1, 0, 32'hFFFF_FF00, 32'h0);
    cycle();
    drive(0, 0, 32'h0, 32'h0);
    checks++; if (rdata !== {24'h0, v}) $display("FAIL sw_read: got %h expected %h", rdata, {24'h0, v}); else passed++;
  endtask

  task automatic test_btn();
    btn = 4'b0100;
    for (int i = 0; i < 4; i++) cycle();
    btn = 4'b0000;
    drive(1, 0, 32'hFFFF_FF04, 32'h0);
    cycle();
    checks++; if (rdata !== 32'h4) $display("FAIL btn_capture: got %h expected 4", rdata); else passed++;
    cycle();
    checks++; if (rdata !== 32'h0) $display("FAIL btn_read_clears: got %h expected 0", rdata); else passed++;
    // Edge reaches the event register on the third edge after the raw rise; read lands on that edge.
    drive(0, 0, 32'h0, 32'h0);
    btn = 4'b0100;
    cycle(); cycle();
    drive(1, 0, 32'hFFFF_FF04, 32'h0);
    cycle();
    checks++; if (rdata !== 32'h0) $display("FAIL btn_race_first: got %h expected 0", rdata); else passed++;
    cycle();
    checks++; if (rdata !== 32'h4) $display("FAIL btn_race_survives: got %h expected 4", rdata); else passed++;
    drive(0, 0, 32'h0, 32'h0);
    btn = 4'b0000;
    cycle(); cycle(); cycle();
  endtask

  task automatic test_timer();
`ifdef MMIO_TIMER_EN
    int waited;
    drive(0, 1, 32'hFFFF_FF14, 32'd5); cycle();
    drive(0, 1, 32'hFFFF_FF10, 32'd0); cycle();
    drive(0, 1, 32'hFFFF_FF18, 32'h2); cycle();
    drive(0, 0, 32'h0, 32'h0);
    waited = 0;
    while (timer_flag !== 1'b1 && waited < 30) begin
      cycle(); waited++;
    end
    checks++; if (timer_flag !== 1'b1) $display("FAIL timer_flag_rise: got %b expected 1 within 30 cycles", timer_flag); else passed++;
    drive(1, 0, 32'hFFFF_FF10, 32'h0); cycle();
    checks++; if (rdata !== exp_rdata || rdata <= 32'd5) $display("FAIL timer_count_passed: got %h expected %h", rdata, exp_rdata); else passed++;
    drive(0, 1, 32'hFFFF_FF18, 32'h3); cycle();
    drive(0, 1, 32'hFFFF_FF18, 32'h3); cycle();
    checks++; if (timer_flag !== 1'b0) $display("FAIL timer_w1c: got %b expected 0", timer_flag); else passed++;
    drive(0, 1, 32'hFFFF_FF10, 32'hFFFF_FFFF); cycle();
    drive(1, 0, 32'hFFFF_FF10, 32'h0); cycle();
    checks++; if (rdata !== 32'hFFFF_FFFF) $display("FAIL timer_load_max: got %h expected ffffffff", rdata); else passed++;
    cycle();
    checks++; if (rdata !== 32'h0) $display("FAIL timer_wrap: got %h expected 0", rdata); else passed++;
    drive(0, 1, 32'hFFFF_FF18, 32'h1); cycle();
    drive(0, 0, 32'h0, 32'h0);
`else
    drive(0, 1, 32'hFFFF_FF14, 32'd0); cycle();
    drive(0, 1, 32'hFFFF_FF18, 32'h2); cycle();
    drive(1, 0, 32'hFFFF_FF10, 32'h0); cycle();
    checks++; if (rdata !== 32'h0) $display("FAIL notimer_tcnt_read: got %h expected 0", rdata); else passed++;
    drive(1, 0, 32'hFFFF_FF18, 32'h0); cycle();
    checks++; if (rdata !== 32'h0) $display("FAIL notimer_tstat_read: got %h expected 0", rdata); else passed++;
    drive(0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) cycle();
    checks++; if (timer_flag !== 1'b0) $display("FAIL notimer_flag: got %b expected 0", timer_flag); else passed++;
`endif
  endtask

  task automatic test_random();
    logic        r, w, hit;
    logic [31:0] a;
    int          k;
    for (int n = 0; n < 400; n++) begin
      r = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        a = $urandom & 32'h0000_00FC;
      end else begin
        k = $urandom_range(0, 9);
        if (k < 7)       a = 32'hFFFF_FF00 + 32'(k * 4);
        else if (k == 7) a = 32'hFFFF_FF1C;
        else if (k == 8) a = 32'hFFFF_FF20;
        else             a = 32'hFFFF_FFFC;
        a[1:0] = 2'($urandom_range(0, 3));
      end
      drive(r, w, a, $urandom);
      if ($urandom_range(0, 5) == 0) btn = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) sw  = 8'($urandom_range(0, 255));
      hit = (a[31:8] == io_base[31:8]);
      #1;
      checks++; if (ram_rd !== (r & ~w & ~hit)) $display("FAIL rnd_ram_rd @%0d: got %b expected %b", n, ram_rd, r & ~w & ~hit); else passed++;
      checks++; if (ram_wr !== (w & ~hit)) $display("FAIL rnd_ram_wr @%0d: got %b expected %b", n, ram_wr, w & ~hit); else passed++;
      cycle();
      checks++; if (rdata !== exp_rdata) $display("FAIL rnd_rdata @%0d: got %h expected %h", n, rdata, exp_rdata); else passed++;
      checks++; if (led_reg !== m_led) $display("FAIL rnd_led @%0d: got %h expected %h", n, led_reg, m_led); else passed++;
      checks++; if (disp_reg !== m_disp) $display("FAIL rnd_disp @%0d: got %h expected %h", n, disp_reg, m_disp); else passed++;
      checks++; if (timer_flag !== m_flag) $display("FAIL rnd_flag @%0d: got %b expected %b", n, timer_flag, m_flag); else passed++;
    end
    drive(0, 0, 32'h0, 32'h0);
    btn = 0;
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 32'hFFFF_FF08, 32'h0000_F00D); cycle();
    drive(1, 0, 32'hFFFF_FF08, 32'h0); cycle();
    drive(0, 1, 32'hFFFF_FF0C, 32'h0000_1234);
    #2 rst_cpu = 1;
    #1;
    checks++; if (led_reg !== 16'h0) $display("FAIL midrst_led: got %h expected 0", led_reg); else passed++;
    checks++; if (disp_reg !== 16'h0) $display("FAIL midrst_disp: got %h expected 0", disp_reg); else passed++;
    checks++; if (rdata !== 32'h0) $display("FAIL midrst_rdata: got %h expected 0", rdata); else passed++;
    checks++; if (timer_flag !== 1'b0) $display("FAIL midrst_flag: got %b expected 0", timer_flag); else passed++;
    drive(0, 0, 32'h0, 32'h0);
    @(negedge clk_cpu); @(negedge clk_cpu);
    rst_cpu = 0;
    model_reset();
    cycle();
    checks++; if (disp_reg !== 16'h0) $display("FAIL postrst_disp: got %h expected 0", disp_reg); else passed++;
  endtask

  initial begin
    io_base = IO_BASE_DFLT;
    model_reset();
    test_reset();
    test_ram_path();
    test_led_disp();
    test_sw();
    test_btn();
    test_timer();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-side responder for the multicycle CPU's load/store port. It decodes every CPU memory access and routes it either to the instruction/data RAM or to a small bank of memory-mapped I/O registers. The I/O bank holds switch and button inputs, LED and seven-segment output registers, and an optional compare timer. It sits between the CPU datapath and the RAM, on the far side of the CPU's MemRead/MemWrite/address/wdata initiator interface.

## Interface
- `IO_BASE`, default 32'hFFFF_FF00: base address of the 256-byte I/O window.
- `clk_cpu` in 1: CPU clock (manual step or board clock).
- `rst_cpu` in 1: reset, asynchronous, active-high.
- `mem_read` in 1: CPU load or fetch request.
- `mem_write` in 1: CPU store request.
- `addr` in 32: byte address. `addr[1:0]` is ignored.
- `wdata` in 32: store data.
- `rdata` out 32: load data, registered.
- `ram_rd` out 1: read strobe forwarded to RAM.
- `ram_wr` out 1: write strobe forwarded to RAM.
- `ram_rdata` in 32: RAM read data, valid one cycle after `ram_rd`.
- `sw` in 8: raw switches.
- `btn` in 4: raw debounced buttons.
- `led_reg` out 16: LED output register.
- `disp_reg` out 16: seven-segment output register.
- `timer_flag` out 1: timer match flag (sticky).

## Operation
- Decode: `io_hit` = (`addr[31:8]` == `IO_BASE[31:8]`).
  - RAM access: `ram_rd` = `mem_read & ~mem_write & ~io_hit`; `ram_wr` = `mem_write & ~io_hit`. Both are combinational.
- I/O map, word offsets `addr[7:0]`:
  - 0x00 SW: read-only, `{24'b0, sw_sync}`.
  - 0x04 BTN: `{28'b0, btn_evt}`. Each bit is set on a rising edge of the synchronized button. A read clears all bits. Writes are ignored.
  - 0x08 LED: read/write, low 16 bits.
  - 0x0C DISP: read/write, low 16 bits.
  - 0x10 TCNT: read/write. A write loads the counter.
  - 0x14 TCMP: read/write.
  - 0x18 TSTAT: bit0 = match flag, write-1-to-clear. bit1 = timer enable, read/write.
  - Any other offset: reads return 0, writes are ignored.
- When `mem_read` and `mem_write` are both high, the access is treated as a write only. `rdata` holds its value and BTN is not cleared.
- `sw` and `btn` pass through a 2-FF synchronizer. The BTN edge detector compares against the second stage.
- Timer:
  - When enabled, TCNT increments by 1 each `clk_cpu` cycle.
  - It wraps 0xFFFF_FFFF to 0 with no side effect.
  - When TCNT == TCMP and the timer is enabled, the flag is set on the next edge.
- Simultaneous-event priorities:
  - A BTN edge arriving in the same cycle as a BTN read: the new bit ends set.
  - A flag set and a W1C write in the same cycle: the set wins.
  - A TCNT write and an increment in the same cycle: the written value wins.

## Timing
- Loads:
  - `rdata` updates on the edge where `mem_read` is sampled high.
  - `rdata` is therefore valid one cycle after the request for both RAM and I/O. A registered `sel_io` steers the mux.
  - `rdata` holds its value between reads.
- Stores: I/O registers update on the edge where `mem_write` is sampled high.
- Reset values: `rdata` = 0, `led_reg` = 0, `disp_reg` = 0, `timer_flag` = 0, TCNT = 0, TCMP = 0xFFFF_FFFF, enable = 0, `btn_evt` = 0, synchronizers = 0.
- Reset mid-access: the access is lost and no RAM strobe is retried. `ram_rd`/`ram_wr` follow their inputs combinationally, so the CPU's own reset deasserts them.

## Configuration
- `MMIO_TIMER_EN` defined: the timer is instantiated and 0x10–0x18 are live.
- `MMIO_TIMER_EN` undefined: 0x10–0x18 read 0, writes there are ignored, and `timer_flag` is tied to 0.

## Structure
- Package `mmio_pkg`: `IO_BASE` default and the offset constants `OFS_SW`, `OFS_BTN`, `OFS_LED`, `OFS_DISP`, `OFS_TCNT`, `OFS_TCMP`, `OFS_TSTAT`.
- Sub-module `mmio_timer`: owns TCNT, TCMP, enable and flag. It takes the write strobes and wdata, and exports the register values and `timer_flag`.

## Test plan
- RAM path: store 0x1234_5678 to 0x40 → `ram_wr`=1 and `ram_rd`=0. Then load 0x40 with `ram_rdata`=0x1234_5678 → `rdata`=0x1234_5678 one cycle later.
- LED/DISP: store 0xABCD to 0xFFFF_FF08 → `led_reg`=0xABCD and `ram_wr`=0. Load 0xFFFF_FF20 (unmapped) → `rdata`=0.
- BTN capture: pulse `btn[2]` → load 0xFFFF_FF04 returns 0x4. A second load returns 0. An edge in the same cycle as the read → the next load returns the bit set.
- Timer: write TCMP=5, TSTAT=0x2 → `timer_flag` rises once TCNT has passed 5. Write TSTAT=0x1 → flag clears. Load TCNT=0xFFFF_FFFF → it wraps to 0.
- Reset: assert `rst_cpu` asynchronously mid-store → all outputs return to their reset values immediately.
- With `MMIO_TIMER_EN` undefined: load 0xFFFF_FF10 → 0, and `timer_flag` stays 0.
